usb_rx_pkt_ctrl: RTL
====================

Name: usb_rx_pkt_ctrl

Overview:
Packet-level controller that sequences the USB receive datapath. It watches the receiver's rcving/r_error/PID status, drains payload bytes from the receive FIFO through a valid/ready byte stream, counts them, and classifies and validates each packet. It sits between the USB receiver and the downstream packet buffer or endpoint logic, and issues one completion pulse per packet.

Parameters:
MAX_BYTES, 64, largest legal byte count per packet (payload + CRC); exceeding it is an error
LEN_W, 7, width of pkt_len; must satisfy 2^LEN_W > MAX_BYTES

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high (already decided)
rcving  in  1  receiver busy with a packet, high from SYNC to EOP
r_error  in  1  receiver error flag; sticky until next packet
pid  in  4  decoded PID of current packet; valid while rcving is high
fifo_empty  in  1  receive FIFO empty
fifo_rdata  in  8  head of FIFO (first-word fall-through)
fifo_ren  out  1  pop FIFO head this cycle
out_data  out  8  forwarded byte, registered
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
pkt_done  out  1  one-cycle pulse: packet finished
pkt_type  out  2  00 token, 01 data, 10 handshake, 11 invalid; held from pkt_done until next start
pkt_len  out  LEN_W  bytes popped for the packet; held as pkt_type
pkt_err  out  1  packet error; held as pkt_type

Behaviour:
- Reset: state IDLE. All outputs 0; internal counters, error flag and PID latch cleared.
- Reset mid-packet: abandon the packet; no pkt_done is issued. FIFO contents are left for the receiver/FIFO reset to clear.
- States: IDLE, RECV, DRAIN, FLUSH, CHECK, DONE.
- IDLE: on a rising edge of rcving (registered previous value 0, current 1), clear len and err, latch pid, go to RECV.
- Pop rule for RECV and DRAIN: fifo_ren = !fifo_empty && (!out_valid || out_ready).
  - On a pop, out_data <= fifo_rdata, out_valid <= 1, len += 1.
  - out_valid clears when out_ready is high and no pop occurs.
  - Throughput is 1 byte/cycle with out_ready tied high.
- RECV:
  - rcving falls -> DRAIN.
  - r_error high -> set err, go to FLUSH.
  - A pop that would make len exceed MAX_BYTES -> set err, do not forward that byte, go to FLUSH.
- DRAIN:
  - Same pop rule.
  - fifo_empty && !out_valid -> CHECK. Do not leave while a forwarded byte is still pending.
- FLUSH:
  - fifo_ren = !fifo_empty. Bytes are discarded and len is not incremented.
  - out_valid may still complete its pending byte.
  - Exit to CHECK when !rcving && fifo_empty && !out_valid.
- CHECK: classify the latched PID; go to DONE in one cycle.
  - OUT 0001, IN 1001, SETUP 1101 -> token; len must be exactly 2.
  - DATA0 0011, DATA1 1011 -> data; len must be at least 2 (CRC16).
  - ACK 0010, NAK 1010, STALL 1110 -> handshake; len must be 0.
  - Any other PID -> invalid, err = 1.
  - Length mismatch sets err.
- DONE: pkt_done = 1 for one cycle, registered outputs updated, go to IDLE.
  - If a rcving rise is sampled in DONE, it is recorded and IDLE moves directly to RECV next cycle; no packet is lost.
- Simultaneous events:
  - r_error together with rcving fall -> FLUSH (error wins).
  - An overflow pop is treated as an error pop.
- Latency: last FIFO byte to pkt_done is 3 cycles with out_ready high (pop/forward, DRAIN exit, CHECK, DONE).
- Bytes already forwarded before an error are not recalled; downstream must drop the packet on pkt_err.

Decomposition:
- Package usb_pkg:
  - PID constants: PID_OUT, PID_IN, PID_SETUP, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL.
  - pkt_type_t enum: TOKEN, DATA, HSHAKE, INVALID.
  - rx_ctrl_state_t enum.
  - Function pid_class(pid) returning pkt_type_t.
- Sub-module usb_pid_classify: combinational classification of PID plus length check, producing pkt_type and len_ok. Everything else stays in one FSM module.

Test Plan:
- Stream an OUT token (pid 0001) with 2 bytes, out_ready=1 -> out_data 0x??/0x?? each forwarded once; pkt_done with type 00, len 2, err 0, 3 cycles after last pop.
- DATA1 (1011) with 10 bytes, out_ready toggling 1/0 -> all 10 bytes in order, no drops or duplicates; fifo_ren never high while out_valid && !out_ready; pkt_len 10, err 0.
- ACK (0010) with 0 bytes -> no fifo_ren; pkt_done type 10, len 0, err 0. Same ACK with 1 stray byte -> err 1.
- DATA0 with 70 bytes, MAX_BYTES 64 -> exactly 64 bytes forwarded; remaining 6 popped and discarded; pkt_len 64, pkt_err 1; FIFO empty afterwards.
- r_error asserted after byte 3 of a DATA0 packet -> FLUSH drains FIFO; pkt_err 1, pkt_len 3. Invalid PID 0000 -> type 11, err 1.
- Back-to-back: rcving rises during DONE -> second packet is fully processed. rst pulsed mid-RECV -> all outputs 0 next cycle; no pkt_done.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared PID codes, packet classes and controller states for the USB receive path.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        TOKEN   = 2'b00,
        DATA    = 2'b01,
        HSHAKE  = 2'b10,
        INVALID = 2'b11
    } pkt_type_t;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DRAIN,
        FLUSH,
        CHECK,
        DONE
    } rx_ctrl_state_t;

    function automatic pkt_type_t pid_class(input logic [3:0] pid);
        case (pid)
            PID_OUT, PID_IN, PID_SETUP:   return TOKEN;
            PID_DATA0, PID_DATA1:         return DATA;
            PID_ACK, PID_NAK, PID_STALL:  return HSHAKE;
            default:                      return INVALID;
        endcase
    endfunction

endpackage

// File: rtl/usb_pid_classify.sv
// Classifies a latched PID and checks the popped byte count against its class.
module usb_pid_classify
    import usb_pkg::*;
#(
    parameter int LEN_W = 7
) (
    input  logic [3:0]       pid,
    input  logic [LEN_W-1:0] len,
    output pkt_type_t        pkt_type,
    output logic             len_ok
);

    always_comb begin
        pkt_type = pid_class(pid);
        len_ok   = 1'b0;
        case (pkt_type)
            TOKEN:   len_ok = (len == LEN_W'(2));
            DATA:    len_ok = (len >= LEN_W'(2));   // CRC16 at minimum
            HSHAKE:  len_ok = (len == '0);
            default: len_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Packet-level sequencer for the USB receive path: drains the RX FIFO into a
// valid/ready byte stream, counts bytes and reports one classified result per packet.
module usb_rx_pkt_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rcving,
    input  logic             r_error,
    input  logic [3:0]       pid,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_rdata,
    output logic             fifo_ren,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pkt_done,
    output logic [1:0]       pkt_type,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_err
);

    rx_ctrl_state_t   state, state_next;
    logic             rcving_q;
    logic             pending;
    logic [3:0]       pid_q;
    logic [LEN_W-1:0] len;
    logic             err;

    logic             rise;
    logic             can_pop;
    logic             at_max;
    logic             out_free;
    logic             start;
    logic             fwd;
    logic             set_err;
    pkt_type_t        cls_type;
    logic             len_ok;

    assign rise     = rcving & ~rcving_q;
    assign out_free = ~out_valid | out_ready;
    assign can_pop  = ~fifo_empty & out_free;
    assign at_max   = (len == LEN_W'(MAX_BYTES));

    usb_pid_classify #(.LEN_W(LEN_W)) u_classify (
        .pid      (pid_q),
        .len      (len),
        .pkt_type (cls_type),
        .len_ok   (len_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        fifo_ren   = 1'b0;
        fwd        = 1'b0;
        set_err    = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (rise || pending) begin
                    start      = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                // Error pops and overflow pops both discard the byte.
                if (r_error) begin
                    fifo_ren   = ~fifo_empty;
                    set_err    = 1'b1;
                    state_next = FLUSH;
                end else if (can_pop && at_max) begin
                    fifo_ren   = 1'b1;
                    set_err    = 1'b1;
                    state_next = FLUSH;
                end else begin
                    fifo_ren = can_pop;
                    fwd      = can_pop;
                    if (!rcving) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (can_pop && at_max) begin
                    fifo_ren   = 1'b1;
                    set_err    = 1'b1;
                    state_next = FLUSH;
                end else if (can_pop) begin
                    fifo_ren = 1'b1;
                    fwd      = 1'b1;
                end else if (fifo_empty && out_free) begin
                    state_next = CHECK;
                end
            end
            FLUSH: begin
                fifo_ren = ~fifo_empty;
                if (!rcving && fifo_empty && out_free) state_next = CHECK;
            end
            CHECK:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) fifo_ren = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcving_q  <= 1'b0;
            pending   <= 1'b0;
            pid_q     <= '0;
            len       <= '0;
            err       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_type  <= '0;
            pkt_len   <= '0;
            pkt_err   <= 1'b0;
        end else begin
            rcving_q <= rcving;
            pkt_done <= (state == CHECK);

            if (fwd) begin
                out_data  <= fifo_rdata;
                out_valid <= 1'b1;
                len       <= len + LEN_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (start) begin
                len   <= '0;
                err   <= 1'b0;
                pid_q <= pid;
            end else if (set_err) begin
                err <= 1'b1;
            end

            // A start seen while finishing the previous packet is replayed from IDLE.
            if (start)
                pending <= 1'b0;
            else if ((state == CHECK || state == DONE) && rise)
                pending <= 1'b1;

            if (state == CHECK) begin
                pkt_type <= cls_type;
                pkt_len  <= len;
                pkt_err  <= err | ~len_ok;
            end
        end
    end

endmodule
